// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, one bit per cycle.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_div_unit_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic                 dbz_q, dbz_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 accept, sgn_a, sgn_b;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step, mul_res;
  logic [WIDTH-1:0]     quo, rem;

  assign accept = bus.start && (state_q != S_RUN);
  assign sgn_a  = ~bus.op[0] & bus.a[WIDTH-1];
  assign sgn_b  = ~bus.op[0] & bus.b[WIDTH-1];
  assign abs_a  = sgn_a ? ('0 - bus.a) : bus.a;
  assign abs_b  = sgn_b ? ('0 - bus.b) : bus.b;

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_step  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  assign mul_res = (sa_q ^ sb_q) ? ('0 - mul_step) : mul_step;
  assign quo     = (sa_q ^ sb_q) ? ('0 - div_step[WIDTH-1:0]) : div_step[WIDTH-1:0];
  assign rem     = sa_q ? ('0 - div_step[2*WIDTH-1:WIDTH]) : div_step[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  always_comb begin
    if (bus.op[0])
      fast_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    else
      fast_prod = $signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a}) * $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b});
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = op_q[1] ? div_step : mul_step;
        if (dbz_q) begin
          // dividend magnitude still sits in the low half; restore its sign for HI
          state_d = S_FIN;
          lo_d    = '1;
          hi_d    = sa_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        end else if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIN;
          if (op_q[1]) begin
            lo_d = quo;
            hi_d = rem;
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end
      end
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_RUN;
          op_d    = bus.op;
          sa_d    = sgn_a;
          sb_d    = sgn_b;
          cnt_d   = '0;
          dbz_d   = bus.op[1] && (bus.b == '0);
          opnd_d  = bus.op[1] ? abs_b : abs_a;
          acc_d   = {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
`ifdef MULDIV_FAST_MUL_EN
          if (!bus.op[1]) begin
            state_d      = S_FIN;
            {hi_d, lo_d} = fast_prod;
          end
`endif
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_FIN);
  assign bus.div_by_zero = (state_q == S_FIN) && dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
